// File: rtl/conv_pkg.sv
// Shared types and helpers for the layer-1 conv window reader.
// Build option: CONV_ZERO_PAD_EN adds a one-pixel zero border around the image.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    EMIT,
    DONE
  } conv_state_e;

`ifdef CONV_ZERO_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif

  // Number of window origins along one axis.
  function automatic int out_dim(input int img, input int k, input int stride, input int pad);
    return (img + 2 * pad - k) / stride + 1;
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Window origin and (i,j) slot counters with read-address generation.
// Build option: CONV_ZERO_PAD_EN (through conv_pkg::PAD) shifts origins to (-1,-1) and flags border slots.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int ADDR_W = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         step,
  input  logic                         adv,
  output logic [ADDR_W-1:0]            addr,
  output logic                         in_bounds,
  output logic [$clog2(K*K+1)-1:0]     slot,
  output logic                         last_slot,
  output logic                         last_win
);

  localparam int SW    = $clog2(K * K + 1);
  localparam int CW    = $clog2(IMG_W + IMG_H + 4);
  localparam int OUT_W = out_dim(IMG_W, K, STRIDE, PAD);
  localparam int OUT_H = out_dim(IMG_H, K, STRIDE, PAD);

  localparam logic [CW-1:0] K_MAX  = CW'(K - 1);
  localparam logic [CW-1:0] OX_MAX = CW'(OUT_W - 1);
  localparam logic [CW-1:0] OY_MAX = CW'(OUT_H - 1);

  logic [CW-1:0] i_q, i_d, j_q, j_d, ox_q, ox_d, oy_q, oy_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_q  <= '0;
      j_q  <= '0;
      ox_q <= '0;
      oy_q <= '0;
    end else begin
      i_q  <= i_d;
      j_q  <= j_d;
      ox_q <= ox_d;
      oy_q <= oy_d;
    end
  end

  always_comb begin
    i_d  = i_q;
    j_d  = j_q;
    ox_d = ox_q;
    oy_d = oy_q;
    if (clr) begin
      i_d  = '0;
      j_d  = '0;
      ox_d = '0;
      oy_d = '0;
    end else begin
      // j is the inner index; the slot pair wraps to (0,0) after the last slot.
      if (step) begin
        if (j_q == K_MAX) begin
          j_d = '0;
          i_d = (i_q == K_MAX) ? '0 : i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      if (adv) begin
        if (ox_q == OX_MAX) begin
          ox_d = '0;
          oy_d = oy_q + 1'b1;
        end else begin
          ox_d = ox_q + 1'b1;
        end
      end
    end
  end

  int pix_r, pix_c, pix_a;

  always_comb begin
    pix_r     = int'(oy_q) * STRIDE + int'(i_q) - PAD;
    pix_c     = int'(ox_q) * STRIDE + int'(j_q) - PAD;
    pix_a     = pix_r * IMG_W + pix_c;
    in_bounds = (pix_r >= 0) && (pix_r < IMG_H) && (pix_c >= 0) && (pix_c < IMG_W);
    addr      = in_bounds ? pix_a[ADDR_W-1:0] : '0;
    slot      = SW'(int'(i_q) * K + int'(j_q));
    last_slot = (i_q == K_MAX) && (j_q == K_MAX);
    last_win  = (ox_q == OX_MAX) && (oy_q == OY_MAX);
  end

endmodule

// File: rtl/conv_window_reader.sv
// Layer-1 memory-read stage: fetches KxK windows in raster order and hands them to the PE.
// Build option: CONV_ZERO_PAD_EN enables a zero border (border slots load 0 without a memory read).
module conv_window_reader
  import conv_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic [K*K*DATA_W-1:0]   win_data,
  output logic                    win_valid,
  input  logic                    win_ready,
  output logic                    win_last,
  output logic                    done,
  output conv_state_e             dbg_state
);

  localparam int SW = $clog2(K * K + 1);

  // Handshake: a window moves on any cycle where win_valid and win_ready are both high;
  // win_valid stays high and win_data/win_last stay stable until that cycle.

  conv_state_e           state_q, state_d;
  logic [K*K*DATA_W-1:0] win_data_q, win_data_d;
  logic                  pend_q, pend_d;
  logic [SW-1:0]         pend_idx_q, pend_idx_d;
  logic                  pend_pad_q, pend_pad_d;

  logic              clr, step, adv;
  logic [ADDR_W-1:0] gen_addr;
  logic              gen_in_bounds, gen_last_slot, gen_last_win;
  logic [SW-1:0]     gen_slot;

  conv_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .K     (K),
    .STRIDE(STRIDE),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .step     (step),
    .adv      (adv),
    .addr     (gen_addr),
    .in_bounds(gen_in_bounds),
    .slot     (gen_slot),
    .last_slot(gen_last_slot),
    .last_win (gen_last_win)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      win_data_q <= '0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      pend_pad_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_data_q <= win_data_d;
      pend_q     <= pend_d;
      pend_idx_q <= pend_idx_d;
      pend_pad_q <= pend_pad_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    win_data_d = win_data_q;
    pend_d     = 1'b0;
    pend_idx_d = pend_idx_q;
    pend_pad_d = 1'b0;
    mem_rd_en  = 1'b0;
    mem_addr   = '0;
    win_valid  = 1'b0;
    win_last   = 1'b0;
    done       = 1'b0;
    clr        = 1'b0;
    step       = 1'b0;
    adv        = 1'b0;

    // Read data lags the issue by one cycle, so land it in the slot issued last cycle.
    if (pend_q) begin
      win_data_d[int'(pend_idx_q)*DATA_W +: DATA_W] = pend_pad_q ? '0 : mem_rdata;
    end

    unique case (state_q)
      IDLE: begin
        clr = 1'b1;
        if (start) state_d = FETCH;
      end
      FETCH: begin
        mem_rd_en  = gen_in_bounds;
        mem_addr   = gen_addr;
        pend_d     = 1'b1;
        pend_idx_d = gen_slot;
        pend_pad_d = !gen_in_bounds;
        step       = 1'b1;
        if (gen_last_slot) state_d = WAIT;
      end
      WAIT: begin
        state_d = EMIT;
      end
      EMIT: begin
        win_valid = 1'b1;
        win_last  = gen_last_win;
        if (win_ready) begin
          if (gen_last_win) begin
            state_d = DONE;
          end else begin
            adv     = 1'b1;
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        done = 1'b1;
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Dropping start mid-frame discards the partial window and suppresses any transfer this cycle.
    if (!start && (state_q inside {FETCH, WAIT, EMIT})) begin
      state_d    = IDLE;
      win_data_d = '0;
      pend_d     = 1'b0;
      clr        = 1'b1;
      step       = 1'b0;
      adv        = 1'b0;
      mem_rd_en  = 1'b0;
      mem_addr   = '0;
      win_valid  = 1'b0;
      win_last   = 1'b0;
    end
  end

  assign win_data  = win_data_q;
  assign dbg_state = state_q;

endmodule
